// File: rtl/regs_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between writeback
// sources, with a registered write port and a per-GPR pending-write scoreboard.
module regs_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic                        rsv_en_i,
  input  logic [ADDR_W-1:0]           rsv_addr_i,
  input  logic                        flush_i,
  output logic                        wb_wen_o,
  output logic [ADDR_W-1:0]           wb_addr_o,
  output logic [DATA_W-1:0]           wb_data_o,
  output logic [31:0]                 busy_o
);

  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NUM_GPR = 32;

  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   idx;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_vld;
  logic [NUM_REQ-1:0] grant;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic [NUM_GPR-1:0] busy_nxt;

  // Search from ptr+1 with wrap; first valid requester wins.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    gnt_vld  = 1'b0;
    idx      = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = PTR_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!gnt_vld && req_valid_i[idx]) begin
        gnt_vld      = 1'b1;
        gnt_idx      = idx;
        grant[idx]   = 1'b1;
        sel_addr     = req_addr_i[32'(idx)*ADDR_W +: ADDR_W];
        sel_data     = req_data_i[32'(idx)*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready_o = grant;

  // Scoreboard update: flush dominates, then reserve beats a same-edge clear.
  always_comb begin
    busy_nxt = busy_o;
    if (flush_i) begin
      busy_nxt = '0;
    end else begin
      if (gnt_vld) busy_nxt[sel_addr] = 1'b0;
      if (rsv_en_i) busy_nxt[rsv_addr_i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q     <= PTR_W'(NUM_REQ - 1);
      wb_wen_o  <= 1'b0;
      wb_addr_o <= '0;
      wb_data_o <= '0;
      busy_o    <= '0;
    end else begin
      if (gnt_vld) begin
        ptr_q     <= gnt_idx;
        wb_addr_o <= sel_addr;
        wb_data_o <= sel_data;
      end
      // x0 transfers are accepted but never written.
      wb_wen_o <= gnt_vld && (sel_addr != '0);
      busy_o   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed bench for regs_wb_arbiter: arbitration order, write port latency,
// x0 suppression, scoreboard reserve/clear/flush and asynchronous reset.
module tb_regs_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  req_valid_i;
  logic [14:0] req_addr_i;
  logic [95:0] req_data_i;
  logic [2:0]  req_ready_o;
  logic        rsv_en_i;
  logic [4:0]  rsv_addr_i;
  logic        flush_i;
  logic        wb_wen_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic [31:0] busy_o;

  int pass_cnt = 0;
  int total    = 0;

  regs_wb_arbiter #(.NUM_REQ(3), .ADDR_W(5), .DATA_W(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .rsv_en_i    (rsv_en_i),
    .rsv_addr_i  (rsv_addr_i),
    .flush_i     (flush_i),
    .wb_wen_o    (wb_wen_o),
    .wb_addr_o   (wb_addr_o),
    .wb_data_o   (wb_data_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr_i[i*5 +: 5]  = a;
    req_data_i[i*32 +: 32] = d;
  endtask

  initial begin
    int exp_i;
    rst_i       = 1'b0;
    req_valid_i = 3'b111;
    req_addr_i  = '0;
    req_data_i  = '0;
    rsv_en_i    = 1'b0;
    rsv_addr_i  = '0;
    flush_i     = 1'b0;
    set_req(0, 5'd10, 32'hA0);
    set_req(1, 5'd11, 32'hB1);
    set_req(2, 5'd12, 32'hC2);

    // Reset held with all requesters valid
    step(); step();
    chk("rst_wen",  32'(wb_wen_o), 32'd0);
    chk("rst_addr", 32'(wb_addr_o), 32'd0);
    chk("rst_data", wb_data_o, 32'd0);
    chk("rst_busy", busy_o, 32'd0);

    // Release: round-robin over six back-to-back cycles starting at req0
    rst_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      exp_i = c % 3;
      #2;
      chk("rr_ready", 32'(req_ready_o), 32'(3'b001 << exp_i));
      step();
      chk("rr_wen",  32'(wb_wen_o), 32'd1);
      chk("rr_addr", 32'(wb_addr_o), 32'(10 + exp_i));
      chk("rr_data", wb_data_o, 32'hA0 + 32'(exp_i) * 32'h11);
    end
    req_valid_i = 3'b000;
    step();
    chk("idle_wen",  32'(wb_wen_o), 32'd0);
    chk("idle_addr", 32'(wb_addr_o), 32'd12);
    chk("idle_data", wb_data_o, 32'hC2);

    // Single write from req0
    set_req(0, 5'd5, 32'hDEADBEEF);
    req_valid_i = 3'b001;
    #2;
    chk("single_ready", 32'(req_ready_o), 32'b001);
    step();
    req_valid_i = 3'b000;
    chk("single_wen",  32'(wb_wen_o), 32'd1);
    chk("single_addr", 32'(wb_addr_o), 32'd5);
    chk("single_data", wb_data_o, 32'hDEADBEEF);

    // Write to x0 is accepted but suppressed
    set_req(1, 5'd0, 32'h1);
    req_valid_i = 3'b010;
    #2;
    chk("x0_ready", 32'(req_ready_o), 32'b010);
    step();
    req_valid_i = 3'b000;
    chk("x0_wen",  32'(wb_wen_o), 32'd0);
    chk("x0_busy", busy_o, 32'd0);

    // Reserving x0 never marks it busy
    rsv_en_i = 1'b1; rsv_addr_i = 5'd0;
    step();
    chk("rsv_x0", busy_o, 32'd0);

    // Scoreboard: reserve x7, then reserve again on the writeback edge
    rsv_addr_i = 5'd7;
    step();
    rsv_en_i = 1'b0;
    chk("rsv_x7", busy_o, 32'h80);
    set_req(2, 5'd7, 32'h77);
    req_valid_i = 3'b100;
    rsv_en_i = 1'b1; rsv_addr_i = 5'd7;
    #2;
    chk("same_edge_ready", 32'(req_ready_o), 32'b100);
    step();
    req_valid_i = 3'b000;
    rsv_en_i = 1'b0;
    chk("same_edge_busy", busy_o, 32'h80);
    chk("same_edge_addr", 32'(wb_addr_o), 32'd7);
    set_req(0, 5'd7, 32'h78);
    req_valid_i = 3'b001;
    #2;
    chk("clr_ready", 32'(req_ready_o), 32'b001);
    step();
    req_valid_i = 3'b000;
    chk("clr_busy", busy_o, 32'd0);
    chk("clr_data", wb_data_o, 32'h78);

    // Flush: clears everything, ignores same-cycle reserve, keeps the write
    rsv_en_i = 1'b1; rsv_addr_i = 5'd3;
    step();
    rsv_addr_i = 5'd9;
    step();
    chk("pre_flush_busy", busy_o, 32'h208);
    rsv_addr_i = 5'd4;
    flush_i = 1'b1;
    set_req(1, 5'd9, 32'h99);
    req_valid_i = 3'b010;
    #2;
    chk("flush_ready", 32'(req_ready_o), 32'b010);
    step();
    flush_i = 1'b0; rsv_en_i = 1'b0; req_valid_i = 3'b000;
    chk("flush_busy", busy_o, 32'd0);
    chk("flush_wen",  32'(wb_wen_o), 32'd1);
    chk("flush_addr", 32'(wb_addr_o), 32'd9);
    chk("flush_data", wb_data_o, 32'h99);

    // Asynchronous reset mid-operation
    set_req(2, 5'd6, 32'h66);
    req_valid_i = 3'b100;
    rsv_en_i = 1'b1; rsv_addr_i = 5'd6;
    step();
    req_valid_i = 3'b000; rsv_en_i = 1'b0;
    chk("pre_rst_busy", busy_o, 32'h40);
    chk("pre_rst_wen",  32'(wb_wen_o), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_rst_wen",  32'(wb_wen_o), 32'd0);
    chk("async_rst_addr", 32'(wb_addr_o), 32'd0);
    chk("async_rst_busy", busy_o, 32'd0);
    step();
    rst_i = 1'b1;
    req_valid_i = 3'b111;
    #2;
    chk("post_rst_ready", 32'(req_ready_o), 32'b001);
    step();
    req_valid_i = 3'b000;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
